// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, stall/flush control and saturating stall/flush event counters.
module pipe_stage_skid #(
    parameter int DATA_W     = 64,
    parameter int SKID_EN    = 1,
    parameter int FLUSH_ZERO = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              cnt_clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic accept;
    logic consume;
    logic stall_inc;

    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    assign consume = out_valid_o & out_ready_i & ~stall_i;

    // With the skid buffer in_ready is a pure register decode, breaking the ready timing path.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready_o = (state_q != TWO);
        end else begin : g_pass_ready
            assign in_ready_o = (state_q == EMPTY) | consume;
        end
    endgenerate

    assign accept    = in_valid_i & in_ready_o;
    assign stall_inc = out_valid_o & ~consume & ~flush_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            if (FLUSH_ZERO != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (consume && accept) begin
                        main_d = in_data_i;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end else if (accept && (SKID_EN != 0)) begin
                        skid_d  = in_data_i;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Counters saturate at all-ones; a clear request beats a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
